serial_add_arbiter: RTL and testbench
=====================================

# serial_add_arbiter

Controller that shares one serial-adder datapath (two shift-register operand regs, carry flop, sum shift reg) between two requesters. It arbitrates round-robin, loads the winner's operands, sequences the bit-serial shifts, and captures the sum. It returns the sum with a one-cycle done pulse. It sits between requester logic and the datapath and replaces the single-user start/enable/load FSM.

## Interface
- n, 8, operand width; sum width is n+1
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  request per requester; held until matching done
- a0, b0  in  n  operands of requester 0; stable while req[0]
- a1, b1  in  n  operands of requester 1; stable while req[1]
- gnt  out  2  one-hot grant, high LOAD through DONE
- busy  out  1  high in any state except IDLE
- dp_a, dp_b  out  n  granted operands, driven to datapath parallel inputs
- dp_load  out  1  parallel-load operand regs
- dp_enable  out  1  shift enable for all datapath regs
- dp_clear  out  1  clear carry flop and sum reg (qualified by dp_enable in datapath)
- dp_sum  in  n+1  datapath sum shift register
- done  out  2  one-cycle pulse to the served requester
- result  out  n+1  captured sum, held until next DONE

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: when req != 0, pick the winner and go to LOAD. A single requester wins. If both request, the requester at the priority pointer wins. Set gnt.
- LOAD (1 cycle): dp_load=1, dp_enable=1, dp_clear=1. dp_a/dp_b = winner's operands.
- SHIFT (exactly n+1 cycles): dp_enable=1, dp_load=0, dp_clear=0. A bit counter runs 0..n. Leave SHIFT when count==n. The (n+1)th shift moves the final carry into sum MSB.
- DONE (1 cycle): result <= dp_sum; done[winner]=1; pointer <= the other requester. Always return to IDLE.
- dp_a/dp_b = 0 when gnt==0.
- req deasserted mid-operation: ignored. The operation completes and done still pulses.
- req of the non-granted requester during an operation is not queued. It is re-evaluated in IDLE.
- Sum is unsigned n+1 bits, so it never overflows. Example: 255+255 = 9'd510.
- Reset (any state, including mid-SHIFT): state=IDLE, counter=0, pointer=0, gnt=0, done=0, busy=0, result=0, all dp_* control outputs=0. The datapath is left as-is and is re-cleared by the next LOAD.

## Timing
- All outputs are registered or decoded from registered state; no combinational path from req to outputs.
- Edge E0 samples req in IDLE. Then:
  - LOAD is cycle E0..E1.
  - SHIFT is E1..E(n+2).
  - DONE is E(n+2)..E(n+3).
  - done is visible for 1 cycle, n+2 edges after E0 (10 for n=8).
- result is updated at the end of DONE, i.e. valid from edge E(n+3) on.
- IDLE lasts at least 1 cycle between operations. Back-to-back throughput is one sum per n+4 cycles.
- Pointer update and the IDLE arbitration never coincide, since DONE always precedes IDLE.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, LOAD, SHIFT, DONE);
  - the default width constant N=8;
  - the count width $clog2(N+1).
- One sub-module: rr_arbiter2. It is combinational winner selection from req and the pointer, plus the registered pointer with its update input. FSM, counter and result register stay in the top.

## Test plan
Bench instantiates the real shift-register datapath and full adder driven by dp_*.
- Single request: req0, a0=100, b0=55 → gnt=01 for n+3 cycles; done[0] pulses once at E10; result=9'd155; busy low afterwards.
- Carry out: req1, a1=255, b1=255 → done[1] pulse; result=9'd510.
- Simultaneous requests after reset: req=11, a0=3, b0=4, a1=10, b1=20 → requester 0 served first (result 7), requester 1 next (result 30); done pulses n+4 cycles apart.
- Fairness: req0 held continuously, req1 raised during requester 0's SHIFT → grants alternate 0,1,0.
- Req dropped: req0 deasserted in the 3rd SHIFT cycle → operation completes; done[0] pulses; result correct.
- Reset mid-SHIFT (assert in the 4th SHIFT cycle) → all outputs 0 immediately and result=0. A new req0 with 1+1 gives result=2 with no carry left over.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial-adder arbiter: controller state encoding,
// default operand width, and the width of the shift counter that runs 0..N.
package serial_pkg;

  // Default operand width; the sum is one bit wider.
  localparam int N = 8;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/serial_add_arbiter_rr.sv
// rr_arbiter2: two-way round-robin winner selection.
// A lone requester always wins; on a tie the requester named by the pointer
// wins. The pointer moves to the other requester when an operation finishes.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset (pointer -> 0)
//   req_i         request vector
//   update_i      advance the pointer this cycle
//   served_i      index of the requester that was just served
//   grant_o       one-hot winner (combinational from req_i and pointer)
module rr_arbiter2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic [1:0] grant_o
);

  logic ptr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= 1'b0;
    end else if (update_i) begin
      ptr_q <= ~served_i;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/serial_add_arbiter.sv
// serial_add_arbiter: shares one bit-serial adder datapath between two
// requesters. Arbitrates round-robin, loads the winner's operands, runs N+1
// shifts (the last one moves the final carry into the sum MSB), captures the
// sum and pulses done to the served requester.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_i[1:0]            requests, held until the matching done
//   a0_i, b0_i, a1_i, b1_i  operands per requester
//   gnt_o[1:0]            one-hot grant, high LOAD through DONE
//   busy_o                high in any state but IDLE
//   dp_a_o, dp_b_o        granted operands to datapath parallel inputs
//   dp_load_o, dp_enable_o, dp_clear_o  datapath controls
//   dp_sum_i              datapath sum shift register
//   done_o[1:0]           one-cycle pulse to the served requester
//   result_o              captured sum, held until the next DONE
module serial_add_arbiter
  import serial_pkg::*;
#(
  parameter int N = serial_pkg::N
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   req_i,
  input  logic [N-1:0] a0_i,
  input  logic [N-1:0] b0_i,
  input  logic [N-1:0] a1_i,
  input  logic [N-1:0] b1_i,
  output logic [1:0]   gnt_o,
  output logic         busy_o,
  output logic [N-1:0] dp_a_o,
  output logic [N-1:0] dp_b_o,
  output logic         dp_load_o,
  output logic         dp_enable_o,
  output logic         dp_clear_o,
  input  logic [N:0]   dp_sum_i,
  output logic [1:0]   done_o,
  output logic [N:0]   result_o
);

  localparam int CW = cnt_width(N);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    gnt_q, gnt_d;
  logic [N:0]    result_q, result_d;

  logic [1:0]    arb_grant;
  logic          ptr_update;

  rr_arbiter2 u_arb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .update_i (ptr_update),
    .served_i (gnt_q[1]),
    .grant_o  (arb_grant)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    result_d   = result_q;
    ptr_update = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i != 2'b00) begin
          state_d = ST_LOAD;
          gnt_d   = arb_grant;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        // N+1 shifts: count 0..N, leave on the cycle where count == N.
        if (cnt_q == CW'(N)) begin
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        gnt_d      = 2'b00;
        result_d   = dp_sum_i;
        ptr_update = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      gnt_q    <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gnt_q    <= gnt_d;
      result_q <= result_d;
    end
  end

  // Outputs are decoded from registered state only; req_i never reaches them.
  assign gnt_o       = gnt_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign dp_load_o   = (state_q == ST_LOAD);
  assign dp_clear_o  = (state_q == ST_LOAD);
  assign dp_enable_o = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done_o      = (state_q == ST_DONE) ? gnt_q : 2'b00;
  assign result_o    = result_q;

  always_comb begin
    dp_a_o = '0;
    dp_b_o = '0;
    if (gnt_q[0]) begin
      dp_a_o = a0_i;
      dp_b_o = b0_i;
    end else if (gnt_q[1]) begin
      dp_a_o = a1_i;
      dp_b_o = b1_i;
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter with a bit-serial adder datapath model
// (operand shift regs, carry flop, sum shift reg) driven by the dp_* outputs.
module tb_serial_add_arbiter;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [N-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy;
  logic [N-1:0] dp_a, dp_b;
  logic         dp_load, dp_enable, dp_clear;
  logic [N:0]   dp_sum;
  logic [1:0]   done;
  logic [N:0]   result;

  int n_total = 0;
  int n_pass  = 0;
  int cycle_q = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle_q <= cycle_q + 1;

  serial_add_arbiter #(.N(N)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .a0_i        (a0),
    .b0_i        (b0),
    .a1_i        (a1),
    .b1_i        (b1),
    .gnt_o       (gnt),
    .busy_o      (busy),
    .dp_a_o      (dp_a),
    .dp_b_o      (dp_b),
    .dp_load_o   (dp_load),
    .dp_enable_o (dp_enable),
    .dp_clear_o  (dp_clear),
    .dp_sum_i    (dp_sum),
    .done_o      (done),
    .result_o    (result)
  );

  // Bit-serial adder datapath; not reset, re-cleared by each LOAD.
  logic [N-1:0] ra, rb;
  logic         rc;
  logic [N:0]   rs;
  assign dp_sum = rs;

  always @(posedge clk) begin
    if (dp_enable) begin
      if (dp_load) begin
        ra <= dp_a;
        rb <= dp_b;
      end else begin
        ra <= ra >> 1;
        rb <= rb >> 1;
      end
      if (dp_clear) begin
        rc <= 1'b0;
        rs <= '0;
      end else begin
        rc <= (ra[0] & rb[0]) | (rc & (ra[0] ^ rb[0]));
        rs <= {ra[0] ^ rb[0] ^ rc, rs[N:1]};
      end
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Polls for a done pulse (bounded). Requesters in drop_mask release their
  // request on seeing their done.
  task automatic await_done(input logic [1:0] drop_mask,
                            output logic [1:0] seen, output int at_cycle);
    seen     = 2'b00;
    at_cycle = -1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done != 2'b00) begin
        seen     = done;
        at_cycle = cycle_q;
        req      = req & ~(done & drop_mask);
        break;
      end
    end
    if (seen == 2'b00) chk("done_timeout", 0, 1);
  endtask

  task automatic served(input string tag, input logic [1:0] exp_done,
                        input int exp_res, input logic [1:0] drop_mask);
    logic [1:0] d;
    int         c;
    await_done(drop_mask, d, c);
    chk({tag, "_done"}, int'(d), int'(exp_done));
    tick();
    chk({tag, "_result"}, int'(result), exp_res);
    $display("op %s: done=%b result=%0d cycle=%0d", tag, d, result, c);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_gnt"}, int'(gnt), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_ctrl"}, int'({dp_load, dp_enable, dp_clear}), 0);
    chk({tag, "_dp_a"}, int'(dp_a), 0);
  endtask

  initial begin
    logic [1:0] d;
    int         c1, c2;

    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Single request, cycle-by-cycle: 100 + 55.
    req = 2'b01; a0 = 8'd100; b0 = 8'd55;
    for (int k = 0; k <= 11; k++) begin
      tick();
      chk($sformatf("single_gnt_k%0d", k), int'(gnt), (k <= 10) ? 1 : 0);
      chk($sformatf("single_done_k%0d", k), int'(done), (k == 10) ? 1 : 0);
      chk($sformatf("single_busy_k%0d", k), int'(busy), (k <= 10) ? 1 : 0);
      chk($sformatf("single_en_k%0d", k), int'(dp_enable), (k <= 9) ? 1 : 0);
      if (k <= 1) chk($sformatf("single_load_k%0d", k), int'(dp_load), (k == 0) ? 1 : 0);
      if (k == 0) begin
        chk("single_dp_a", int'(dp_a), 100);
        chk("single_dp_b", int'(dp_b), 55);
        chk("single_clear", int'(dp_clear), 1);
      end
      if (k == 10) req = 2'b00;
    end
    chk("single_result", int'(result), 155);
    chk("single_dp_a_idle", int'(dp_a), 0);
    $display("op single: result=%0d", result);

    // Carry out: 255 + 255 on requester 1, with done latency check.
    req = 2'b10; a1 = 8'd255; b1 = 8'd255;
    c1 = cycle_q;
    await_done(2'b11, d, c2);
    chk("carry_done", int'(d), 2);
    chk("carry_latency", c2 - c1, 11);
    tick();
    chk("carry_result", int'(result), 510);
    $display("op carry: result=%0d", result);

    // Simultaneous requests after reset: requester 0 first, then 1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("sim_reset_result", int'(result), 0);
    a0 = 8'd3; b0 = 8'd4; a1 = 8'd10; b1 = 8'd20;
    req = 2'b11;
    await_done(2'b11, d, c1);
    chk("sim_first_done", int'(d), 1);
    tick();
    chk("sim_first_result", int'(result), 7);
    $display("op sim0: result=%0d", result);
    await_done(2'b11, d, c2);
    chk("sim_second_done", int'(d), 2);
    chk("sim_spacing", c2 - c1, N + 4);
    tick();
    chk("sim_second_result", int'(result), 30);
    $display("op sim1: result=%0d", result);

    // Fairness: req0 held, req1 raised during requester 0's SHIFT.
    a0 = 8'd1; b0 = 8'd2; a1 = 8'd5; b1 = 8'd6;
    req = 2'b01;
    tick(); tick(); tick();
    req = 2'b11;
    served("fair0", 2'b01, 3, 2'b10);
    served("fair1", 2'b10, 11, 2'b10);
    served("fair2", 2'b01, 3, 2'b11);

    // Request dropped in the 3rd SHIFT cycle: operation still completes.
    req = 2'b01; a0 = 8'd77; b0 = 8'd88;
    tick(); tick(); tick(); tick();
    req = 2'b00;
    served("drop", 2'b01, 165, 2'b11);

    // Reset in the 4th SHIFT cycle, then a clean 1 + 1.
    req = 2'b01; a0 = 8'd200; b0 = 8'd100;
    for (int k = 0; k < 5; k++) tick();
    chk("rst_mid_busy_before", int'(busy), 1);
    rst = 1'b1; req = 2'b00;
    #1;
    check_idle_outputs("rst_mid");
    tick();
    rst = 1'b0;
    a0 = 8'd1; b0 = 8'd1;
    req = 2'b01;
    served("after_rst", 2'b01, 2, 2'b11);
    chk("after_rst_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
